// File: rtl/core_pkg.sv
// Shared core types: ALU op encoding, opcodes, decoded bundle.
// Imported by decode, skid buffer and the ALU.
package core_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9,
    ALU_BEQ  = 4'd10,
    ALU_BNE  = 4'd11,
    ALU_BLT  = 4'd12,
    ALU_BGE  = 4'd13,
    ALU_BLTU = 4'd14,
    ALU_BGEU = 4'd15
  } alu_op_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  typedef enum logic [1:0] {
    SB_EMPTY = 2'd0,
    SB_ONE   = 2'd1,
    SB_FULL  = 2'd2
  } sb_state_e;

  typedef struct packed {
    alu_op_e     alu_op;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [31:0] pc;
    logic        use_imm;
    logic        reg_write;
    logic        is_branch;
    logic        is_load;
    logic        is_store;
    logic        is_jump;
    logic        illegal;
  } dec_t;

  function automatic alu_op_e alu_map(
    logic [2:0] f3,
    logic       alt
  );
    unique case (f3)
      3'b000: return alt ? ALU_SUB : ALU_ADD;
      3'b001: return ALU_SLL;
      3'b010: return ALU_SLT;
      3'b011: return ALU_SLTU;
      3'b100: return ALU_XOR;
      3'b101: return alt ? ALU_SRA : ALU_SRL;
      3'b110: return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/decode_unit_if.sv
// Decode stage handshake bus: upstream instr in,
// decoded bundle out, plus flush and illegal count.
interface decode_unit_if;
  import core_pkg::*;

  logic        in_valid_i;
  logic        in_ready_o;
  logic [31:0] instr_i;
  logic [31:0] pc_i;
  logic        flush_i;
  logic        out_valid_o;
  logic        out_ready_i;
  alu_op_e     alu_op_o;
  logic [4:0]  rs1_o;
  logic [4:0]  rs2_o;
  logic [4:0]  rd_o;
  logic [31:0] imm_o;
  logic [31:0] pc_o;
  logic        use_imm_o;
  logic        reg_write_o;
  logic        is_branch_o;
  logic        is_load_o;
  logic        is_store_o;
  logic        is_jump_o;
  logic        illegal_o;
  logic [15:0] illegal_cnt_o;

  modport master (
    output in_valid_i, instr_i, pc_i,
    output flush_i, out_ready_i,
    input  in_ready_o, out_valid_o,
    input  alu_op_o, rs1_o, rs2_o, rd_o,
    input  imm_o, pc_o, use_imm_o,
    input  reg_write_o, is_branch_o,
    input  is_load_o, is_store_o,
    input  is_jump_o, illegal_o,
    input  illegal_cnt_o
  );

  modport slave (
    input  in_valid_i, instr_i, pc_i,
    input  flush_i, out_ready_i,
    output in_ready_o, out_valid_o,
    output alu_op_o, rs1_o, rs2_o, rd_o,
    output imm_o, pc_o, use_imm_o,
    output reg_write_o, is_branch_o,
    output is_load_o, is_store_o,
    output is_jump_o, illegal_o,
    output illegal_cnt_o
  );

endinterface

// File: rtl/skid_buf.sv
// Two-entry (main + skid) buffer for pipeline bundles.
// Ready comes only from the state register.
module skid_buf
  import core_pkg::*;
#(
  parameter type T = logic
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  input  logic in_valid,
  output logic in_ready,
  input  T     in_data,
  output logic out_valid,
  input  logic out_ready,
  output T     out_data
);

  sb_state_e state_q;
  sb_state_e state_d;
  T          main_q;
  T          skid_q;
  logic      in_hs;
  logic      out_hs;
  logic      ld_main_in;
  logic      ld_main_skid;
  logic      ld_skid;

  assign in_ready  = (state_q != SB_FULL);
  assign out_valid = (state_q != SB_EMPTY);
  assign out_data  = main_q;
  assign in_hs     = in_valid && in_ready;
  assign out_hs    = out_valid && out_ready;

  // Occupancy state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= SB_EMPTY;
    else        state_q <= state_d;
  end

  // Next occupancy and payload load selects; flush wins
  always_comb begin
    state_d      = state_q;
    ld_main_in   = 1'b0;
    ld_main_skid = 1'b0;
    ld_skid      = 1'b0;
    if (flush) begin
      state_d = SB_EMPTY;
    end else begin
      unique case (state_q)
        SB_EMPTY: begin
          if (in_hs) begin
            state_d    = SB_ONE;
            ld_main_in = 1'b1;
          end
        end
        SB_ONE: begin
          if (in_hs && out_hs) begin
            ld_main_in = 1'b1;
          end else if (in_hs) begin
            state_d = SB_FULL;
            ld_skid = 1'b1;
          end else if (out_hs) begin
            state_d = SB_EMPTY;
          end
        end
        SB_FULL: begin
          if (out_hs) begin
            state_d      = SB_ONE;
            ld_main_skid = 1'b1;
          end
        end
        default: state_d = SB_EMPTY;
      endcase
    end
  end

  // Payload storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (ld_main_in)        main_q <= in_data;
      else if (ld_main_skid) main_q <= skid_q;
      if (ld_skid)           skid_q <= in_data;
    end
  end

endmodule

// File: rtl/decode_unit.sv
// RV32I decode stage: combinational decode into a skid
// buffer, plus a saturating count of delivered illegals.
module decode_unit
  import core_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input logic          clk,
  input logic          rst_n,
  decode_unit_if.slave bus
);

  logic [DATA_WIDTH-1:0] ins;
  logic [6:0]            opc;
  logic [2:0]            f3;
  logic [6:0]            f7;
  logic [31:0]           imm_i;
  logic [31:0]           imm_s;
  logic [31:0]           imm_b;
  logic [31:0]           imm_u;
  logic [31:0]           imm_j;
  logic                  legal;
  dec_t                  dec;
  dec_t                  head;
  logic [15:0]           ill_cnt_q;

  assign ins = bus.instr_i;
  assign opc = ins[6:0];
  assign f3  = ins[14:12];
  assign f7  = ins[31:25];

  assign imm_i = {{20{ins[31]}}, ins[31:20]};
  assign imm_s = {{20{ins[31]}}, ins[31:25], ins[11:7]};
  assign imm_b = {{19{ins[31]}}, ins[31], ins[7],
                  ins[30:25], ins[11:8], 1'b0};
  assign imm_u = {ins[31:12], 12'b0};
  assign imm_j = {{11{ins[31]}}, ins[31], ins[19:12],
                  ins[20], ins[30:21], 1'b0};

  // Decode the incoming word into a bundle
  always_comb begin
    dec       = '0;
    legal     = 1'b1;
    dec.alu_op = ALU_ADD;
    dec.rs1   = ins[19:15];
    dec.rs2   = ins[24:20];
    dec.rd    = ins[11:7];
    dec.pc    = bus.pc_i;
    unique case (opc)
      OPC_OP: begin
        dec.reg_write = 1'b1;
        dec.alu_op    = alu_map(f3, f7[5]);
        legal = (f7 == 7'h00) ||
                (f7 == 7'h20 &&
                 (f3 == 3'b000 || f3 == 3'b101));
      end
      OPC_OPIMM: begin
        dec.reg_write = 1'b1;
        dec.use_imm   = 1'b1;
        dec.imm       = imm_i;
        dec.alu_op    = alu_map(f3,
                          f3 == 3'b101 && f7[5]);
        if (f3 == 3'b001)
          legal = (f7 == 7'h00);
        else if (f3 == 3'b101)
          legal = (f7 == 7'h00) || (f7 == 7'h20);
      end
      OPC_BRANCH: begin
        dec.is_branch = 1'b1;
        dec.imm       = imm_b;
        unique case (f3)
          3'b000:  dec.alu_op = ALU_BEQ;
          3'b001:  dec.alu_op = ALU_BNE;
          3'b100:  dec.alu_op = ALU_BLT;
          3'b101:  dec.alu_op = ALU_BGE;
          3'b110:  dec.alu_op = ALU_BLTU;
          3'b111:  dec.alu_op = ALU_BGEU;
          default: legal = 1'b0;
        endcase
      end
      OPC_LOAD: begin
        dec.is_load   = 1'b1;
        dec.use_imm   = 1'b1;
        dec.reg_write = 1'b1;
        dec.imm       = imm_i;
      end
      OPC_STORE: begin
        dec.is_store = 1'b1;
        dec.use_imm  = 1'b1;
        dec.imm      = imm_s;
      end
      OPC_LUI, OPC_AUIPC: begin
        dec.use_imm   = 1'b1;
        dec.reg_write = 1'b1;
        dec.imm       = imm_u;
      end
      OPC_JAL: begin
        dec.is_jump   = 1'b1;
        dec.use_imm   = 1'b1;
        dec.reg_write = 1'b1;
        dec.imm       = imm_j;
      end
      OPC_JALR: begin
        dec.is_jump   = 1'b1;
        dec.use_imm   = 1'b1;
        dec.reg_write = 1'b1;
        dec.imm       = imm_i;
      end
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      dec.alu_op    = ALU_ADD;
      dec.imm       = '0;
      dec.use_imm   = 1'b0;
      dec.reg_write = 1'b0;
      dec.is_branch = 1'b0;
      dec.is_load   = 1'b0;
      dec.is_store  = 1'b0;
      dec.is_jump   = 1'b0;
      dec.illegal   = 1'b1;
    end
    if (dec.rd == 5'd0) dec.reg_write = 1'b0;
  end

  skid_buf #(
    .T(dec_t)
  ) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (bus.flush_i),
    .in_valid (bus.in_valid_i),
    .in_ready (bus.in_ready_o),
    .in_data  (dec),
    .out_valid(bus.out_valid_o),
    .out_ready(bus.out_ready_i),
    .out_data (head)
  );

  // Count illegal bundles leaving the stage, saturating
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ill_cnt_q <= '0;
    end else if (bus.out_valid_o && bus.out_ready_i &&
                 head.illegal && ill_cnt_q != 16'hFFFF) begin
      ill_cnt_q <= ill_cnt_q + 16'd1;
    end
  end

  assign bus.alu_op_o      = head.alu_op;
  assign bus.rs1_o         = head.rs1;
  assign bus.rs2_o         = head.rs2;
  assign bus.rd_o          = head.rd;
  assign bus.imm_o         = head.imm;
  assign bus.pc_o          = head.pc;
  assign bus.use_imm_o     = head.use_imm;
  assign bus.reg_write_o   = head.reg_write;
  assign bus.is_branch_o   = head.is_branch;
  assign bus.is_load_o     = head.is_load;
  assign bus.is_store_o    = head.is_store;
  assign bus.is_jump_o     = head.is_jump;
  assign bus.illegal_o     = head.illegal;
  assign bus.illegal_cnt_o = ill_cnt_q;

endmodule

// File: tb/tb_decode_unit.sv
// Random + directed bench for decode_unit against a
// queue-based reference model of the decode stage.
module tb_decode_unit;
  import core_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  decode_unit_if bus();

  decode_unit #(.DATA_WIDTH(32)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int total = 0;
  int bad = 0;
  dec_t q[$];
  int cnt_m = 0;
  int op_tbl[8] = '{0, 2, 3, 4, 5, 6, 8, 9};
  int br_tbl[8] = '{10, 11, -1, -1, 12, 13, 14, 15};
  logic [6:0] opcs[9] = '{7'h33, 7'h13, 7'h63, 7'h03,
                          7'h23, 7'h37, 7'h17, 7'h6f, 7'h67};

  task automatic chk(string tag, logic [127:0] got,
                     logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic dec_t model(logic [31:0] w,
                                 logic [31:0] pc);
    dec_t e;
    logic signed [31:0] s;
    int f3;
    int f7;
    int op;
    bit ok;
    s = w;
    f3 = int'(w[14:12]);
    f7 = int'(w[31:25]);
    e = '0;
    e.rs1 = w[19:15];
    e.rs2 = w[24:20];
    e.rd = w[11:7];
    e.pc = pc;
    ok = 1;
    op = 0;
    case (w[6:0])
      7'h33: begin
        ok = (f7 == 0) || (f7 == 32 && (f3 == 0 || f3 == 5));
        op = op_tbl[f3] + ((f7 == 32) ? 1 : 0);
        e.reg_write = 1;
      end
      7'h13: begin
        if (f3 == 1) ok = (f7 == 0);
        else if (f3 == 5) ok = (f7 == 0 || f7 == 32);
        op = op_tbl[f3] + ((f3 == 5 && f7 == 32) ? 1 : 0);
        e.use_imm = 1;
        e.reg_write = 1;
        e.imm = 32'(s >>> 20);
      end
      7'h63: begin
        op = br_tbl[f3];
        ok = (op >= 0);
        e.is_branch = 1;
        e.imm = 32'((s >>> 31) << 12) | (32'(w[7]) << 11) |
                (32'(w[30:25]) << 5) | (32'(w[11:8]) << 1);
      end
      7'h03: begin
        e.is_load = 1;
        e.use_imm = 1;
        e.reg_write = 1;
        e.imm = 32'(s >>> 20);
      end
      7'h23: begin
        e.is_store = 1;
        e.use_imm = 1;
        e.imm = 32'((s >>> 25) << 5) | 32'(w[11:7]);
      end
      7'h37, 7'h17: begin
        e.use_imm = 1;
        e.reg_write = 1;
        e.imm = w & 32'hFFFFF000;
      end
      7'h6f: begin
        e.is_jump = 1;
        e.use_imm = 1;
        e.reg_write = 1;
        e.imm = 32'((s >>> 31) << 20) | (32'(w[19:12]) << 12) |
                (32'(w[20]) << 11) | (32'(w[30:21]) << 1);
      end
      7'h67: begin
        e.is_jump = 1;
        e.use_imm = 1;
        e.reg_write = 1;
        e.imm = 32'(s >>> 20);
      end
      default: ok = 0;
    endcase
    if (!ok) begin
      op = 0;
      e.imm = '0;
      e.use_imm = 0;
      e.reg_write = 0;
      e.is_branch = 0;
      e.is_load = 0;
      e.is_store = 0;
      e.is_jump = 0;
      e.illegal = 1;
    end
    e.alu_op = alu_op_e'(op[3:0]);
    if (e.rd == 5'd0) e.reg_write = 0;
    return e;
  endfunction

  function automatic dec_t observed();
    dec_t o;
    o.alu_op = bus.alu_op_o;
    o.rs1 = bus.rs1_o;
    o.rs2 = bus.rs2_o;
    o.rd = bus.rd_o;
    o.imm = bus.imm_o;
    o.pc = bus.pc_o;
    o.use_imm = bus.use_imm_o;
    o.reg_write = bus.reg_write_o;
    o.is_branch = bus.is_branch_o;
    o.is_load = bus.is_load_o;
    o.is_store = bus.is_store_o;
    o.is_jump = bus.is_jump_o;
    o.illegal = bus.illegal_o;
    return o;
  endfunction

  function automatic logic [31:0] rnd_instr();
    logic [31:0] w;
    int k;
    w = $urandom;
    k = int'($urandom_range(0, 11));
    if (k < 9) w[6:0] = opcs[k];
    case ($urandom_range(0, 3))
      0: w[31:25] = 7'h00;
      1: w[31:25] = 7'h20;
      default: ;
    endcase
    return w;
  endfunction

  task automatic drive(bit v, logic [31:0] ins,
                       logic [31:0] pc, bit rdy, bit fl);
    bus.in_valid_i = v;
    bus.instr_i = ins;
    bus.pc_i = pc;
    bus.out_ready_i = rdy;
    bus.flush_i = fl;
  endtask

  task automatic tick();
    bit ih;
    bit oh;
    ih = bus.in_valid_i && (q.size() < 2);
    oh = bus.out_ready_i && (q.size() > 0);
    if (oh && q[0].illegal && cnt_m < 65535) cnt_m++;
    if (bus.flush_i) begin
      q.delete();
    end else begin
      if (oh) void'(q.pop_front());
      if (ih) q.push_back(model(bus.instr_i, bus.pc_i));
    end
    @(posedge clk);
    #1;
    chk("out_valid", 128'(bus.out_valid_o), 128'(q.size() > 0));
    chk("in_ready", 128'(bus.in_ready_o), 128'(q.size() < 2));
    chk("ill_cnt", 128'(bus.illegal_cnt_o), 128'(cnt_m));
    if (q.size() > 0)
      chk("bundle", 128'(observed()), 128'(q[0]));
  endtask

  task automatic check_reset();
    chk("rst_valid", 128'(bus.out_valid_o), 128'(0));
    chk("rst_ready", 128'(bus.in_ready_o), 128'(1));
    chk("rst_cnt", 128'(bus.illegal_cnt_o), 128'(0));
    chk("rst_fields", 128'(observed()), 128'(0));
  endtask

  initial begin
    drive(0, 32'h0, 32'h0, 0, 0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // sub x0,x1,x2
    drive(1, 32'h40208033, 32'h1000, 0, 0);
    tick();
    chk("sub_valid", 128'(bus.out_valid_o), 128'(1));
    chk("sub_op", 128'(bus.alu_op_o), 128'(1));
    chk("sub_rw", 128'(bus.reg_write_o), 128'(0));
    drive(0, 32'h0, 32'h0, 1, 0);
    tick();

    // beq x0,x0,-4
    drive(1, 32'hFE000EE3, 32'h1004, 0, 0);
    tick();
    chk("beq_op", 128'(bus.alu_op_o), 128'(10));
    chk("beq_br", 128'(bus.is_branch_o), 128'(1));
    chk("beq_imm", 128'(bus.imm_o), 128'(32'hFFFFFFFC));
    drive(0, 32'h0, 32'h0, 1, 0);
    tick();

    // three-deep stream against a stalled consumer
    drive(1, 32'h00100093, 32'h100, 0, 0);
    tick();
    drive(1, 32'h00200113, 32'h104, 0, 0);
    tick();
    chk("stall_ready2", 128'(bus.in_ready_o), 128'(0));
    drive(1, 32'h00300193, 32'h108, 0, 0);
    tick();
    chk("stall_ready3", 128'(bus.in_ready_o), 128'(0));
    chk("stall_pc0", 128'(bus.pc_o), 128'(32'h100));
    drive(0, 32'h0, 32'h0, 1, 0);
    tick();
    chk("drain_pc1", 128'(bus.pc_o), 128'(32'h104));
    chk("drain_v1", 128'(bus.out_valid_o), 128'(1));
    tick();
    chk("drain_v2", 128'(bus.out_valid_o), 128'(0));

    // flush while full with a competing input
    drive(1, 32'h00100093, 32'h200, 0, 0);
    tick();
    drive(1, 32'hFFFFFFFF, 32'h204, 0, 0);
    tick();
    drive(1, 32'h00500293, 32'h208, 0, 1);
    tick();
    chk("flush_valid", 128'(bus.out_valid_o), 128'(0));
    chk("flush_ready", 128'(bus.in_ready_o), 128'(1));
    drive(0, 32'h0, 32'h0, 1, 0);
    repeat (3) tick();

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 9) < 7, rnd_instr(), $urandom,
            $urandom_range(0, 9) < 6, $urandom_range(0, 31) == 0);
      tick();
    end

    // reset pulse while full
    drive(1, 32'hFFFFFFFF, 32'h300, 0, 0);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check_reset();
    q.delete();
    cnt_m = 0;
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 32'h00100093, 32'h400, 0, 0);
    tick();
    chk("post_rst_acc", 128'(bus.out_valid_o), 128'(1));
    drive(0, 32'h0, 32'h0, 1, 0);
    tick();

    // illegal counter saturation
    for (int i = 0; i < 65537; i++) begin
      drive(1, 32'hFFFFFFFF, 32'(i), 1, 0);
      tick();
    end
    drive(0, 32'h0, 32'h0, 1, 0);
    tick();
    chk("sat_cnt", 128'(bus.illegal_cnt_o), 128'(16'hFFFF));
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
